// File: rtl/multdiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: ALU opcodes and FSM
// state encodings.
package multdiv_ctrl_pkg;

  localparam logic [4:0] ALU_MULT = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/multdiv_ctrl.sv
// Sequences an iterative mult/div unit behind the execute stage: capture
// operands, pulse start, stall until ready or timeout, present the result once.
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [4:0]       aluop,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             cancel,
  output logic             md_ctrl_mult,
  output logic             md_ctrl_div,
  output logic [WIDTH-1:0] md_operand_a,
  output logic [WIDTH-1:0] md_operand_b,
  input  logic [WIDTH-1:0] md_result,
  input  logic             md_exception,
  input  logic             md_ready,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             result_valid
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic               mult_q, mult_d, div_q, div_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d;
  logic               rv_q, rv_d;
  logic               busy_q, busy_d;
  logic               is_md, timeout_hit, stall_c;

  assign is_md       = op_valid & ((aluop == ALU_MULT) | (aluop == ALU_DIV));
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    mult_d   = 1'b0;
    div_d    = 1'b0;
    result_d = result_q;
    exc_d    = exc_q;
    rv_d     = 1'b0;
    stall_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (is_md && !cancel) begin
          stall_c  = 1'b1;
          state_d  = ST_ISSUE;
          opa_d    = operand_a;
          opb_d    = operand_b;
          is_div_d = (aluop == ALU_DIV);
          mult_d   = (aluop != ALU_DIV);
          div_d    = (aluop == ALU_DIV);
        end
      end
      ST_ISSUE: begin
        stall_c = 1'b1;
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (md_ready) begin
          result_d = md_result;
          exc_d    = md_exception;
          rv_d     = 1'b1;
          state_d  = ST_DONE;
        end else if (timeout_hit) begin
          result_d = '0;
          exc_d    = 1'b1;
          rv_d     = 1'b1;
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // An abort leaves the previously captured result untouched.
    if (cancel && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      stall_c  = 1'b0;
      rv_d     = 1'b0;
      result_d = result_q;
      exc_d    = exc_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      mult_q   <= 1'b0;
      div_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rv_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      mult_q   <= mult_d;
      div_q    <= div_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rv_q     <= rv_d;
      busy_q   <= busy_d;
    end
  end

  assign stall        = stall_c;
  assign busy         = busy_q;
  assign md_ctrl_mult = mult_q;
  assign md_ctrl_div  = div_q;
  assign md_operand_a = opa_q;
  assign md_operand_b = opb_q;
  assign result       = result_q;
  assign exception    = exc_q;
  // A cancel arriving in DONE withdraws the completion for that cycle.
  assign result_valid = rv_q & ~cancel;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: mult/div completion, timeout, cancel,
// back-to-back issue and mid-operation reset.
module tb_multdiv_ctrl;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 40;
  localparam logic [4:0] OP_MULT = 5'b00110;
  localparam logic [4:0] OP_DIV  = 5'b00111;

  logic             clock = 1'b0;
  logic             reset;
  logic             op_valid;
  logic [4:0]       aluop;
  logic [WIDTH-1:0] operand_a, operand_b;
  logic             cancel;
  logic             md_ctrl_mult, md_ctrl_div;
  logic [WIDTH-1:0] md_operand_a, md_operand_b;
  logic [WIDTH-1:0] md_result;
  logic             md_exception, md_ready;
  logic             stall, busy;
  logic [WIDTH-1:0] result;
  logic             exception, result_valid;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  multdiv_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .aluop(aluop),
    .operand_a(operand_a), .operand_b(operand_b), .cancel(cancel),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_operand_a(md_operand_a), .md_operand_b(md_operand_b),
    .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
    .stall(stall), .busy(busy), .result(result), .exception(exception),
    .result_valid(result_valid)
  );

  task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
    $display("check %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Runs one mult/div instruction; k < 0 means md_ready never arrives.
  // Ends in the DONE cycle (result_valid high), one cycle before the pipeline advances.
  task automatic do_md(input string tag, input logic [4:0] op,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input int k, input logic [WIDTH-1:0] rdy_res, input logic rdy_exc,
                       input int exp_stall, input logic [WIDTH-1:0] exp_res, input logic exp_exc);
    int cyc = 0;
    int stall_cnt = 0;
    int mult_cnt = 0;
    int div_cnt = 0;
    step();
    op_valid = 1'b1; aluop = op; operand_a = a; operand_b = b;
    md_ready = 1'b0; md_result = 32'hDEAD_BEEF; md_exception = 1'b0;
    #1;
    while (!result_valid && cyc < 80) begin
      if (stall) stall_cnt++;
      if (md_ctrl_mult) mult_cnt++;
      if (md_ctrl_div) div_cnt++;
      if (cyc == 1) begin
        chk({tag, " opa"}, md_operand_a, a);
        chk({tag, " opb"}, md_operand_b, b);
        chk({tag, " busy_issue"}, {31'd0, busy}, 32'd1);
      end
      step();
      cyc++;
      md_ready = (k >= 0) && (cyc == 2 + k);
      md_result = md_ready ? rdy_res : 32'hDEAD_BEEF;
      md_exception = md_ready ? rdy_exc : 1'b0;
      #1;
    end
    md_ready = 1'b0;
    chk({tag, " result_valid"}, {31'd0, result_valid}, 32'd1);
    chk({tag, " stall_cycles"}, stall_cnt, exp_stall);
    chk({tag, " stall_done"}, {31'd0, stall}, 32'd0);
    chk({tag, " result"}, result, exp_res);
    chk({tag, " exception"}, {31'd0, exception}, {31'd0, exp_exc});
    chk({tag, " mult_pulses"}, mult_cnt, (op == OP_MULT) ? 32'd1 : 32'd0);
    chk({tag, " div_pulses"}, div_cnt, (op == OP_DIV) ? 32'd1 : 32'd0);
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; aluop = '0; operand_a = '0; operand_b = '0;
    cancel = 1'b0; md_result = '0; md_exception = 1'b0; md_ready = 1'b0;
    step(); step();
    chk("rst md_ctrl", {30'd0, md_ctrl_mult, md_ctrl_div}, 32'd0);
    chk("rst md_opa", md_operand_a, 32'd0);
    chk("rst stall_busy", {30'd0, stall, busy}, 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst exc_rv", {30'd0, exception, result_valid}, 32'd0);
    reset = 1'b0;

    // MULT 7*6, ready in WAIT cycle 3
    do_md("mult7x6", OP_MULT, 32'd7, 32'd6, 3, 32'd42, 1'b0, 6, 32'd42, 1'b0);
    step();
    op_valid = 1'b0; #1;
    chk("mult7x6 hold", result, 32'd42);
    chk("mult7x6 rv_low", {30'd0, result_valid, busy}, 32'd0);

    // DIV 10/0 reports an exception, ready at k=1
    do_md("div10by0", OP_DIV, 32'd10, 32'd0, 1, 32'd0, 1'b1, 4, 32'd0, 1'b1);

    // no ready at all: forced timeout
    do_md("timeout", OP_MULT, 32'd3, 32'd3, -1, 32'd0, 1'b0, TIMEOUT + 2, 32'd0, 1'b1);

    // back-to-back MULTs, second accepted the cycle after the first DONE
    do_md("b2b_3x4", OP_MULT, 32'd3, 32'd4, 0, 32'd12, 1'b0, 3, 32'd12, 1'b0);
    do_md("b2b_5x5", OP_MULT, 32'd5, 32'd5, 0, 32'd25, 1'b0, 3, 32'd25, 1'b0);

    // cancel in WAIT cycle 2
    step();
    op_valid = 1'b1; aluop = OP_MULT; operand_a = 32'd9; operand_b = 32'd9; #1;
    chk("cancel accept_stall", {31'd0, stall}, 32'd1);
    step(); step(); step(); step();
    cancel = 1'b1; op_valid = 1'b0; #1;
    chk("cancel stall_drop", {31'd0, stall}, 32'd0);
    step();
    cancel = 1'b0; md_ready = 1'b1; md_result = 32'd81; #1;
    chk("cancel idle", {30'd0, busy, result_valid}, 32'd0);
    chk("cancel result_kept", result, 32'd25);
    step();
    md_ready = 1'b0; #1;
    chk("cancel late_ready", {30'd0, busy, result_valid}, 32'd0);
    chk("cancel result_still", result, 32'd25);

    // reset in WAIT cycle 1, then a stray ready
    step();
    op_valid = 1'b1; aluop = OP_DIV; operand_a = 32'd8; operand_b = 32'd2; #1;
    step(); step(); step();
    reset = 1'b1; op_valid = 1'b0; #1;
    step();
    chk("rst2 md_ctrl", {30'd0, md_ctrl_mult, md_ctrl_div}, 32'd0);
    chk("rst2 operands", md_operand_a | md_operand_b, 32'd0);
    chk("rst2 stall_busy", {30'd0, stall, busy}, 32'd0);
    chk("rst2 result", result, 32'd0);
    chk("rst2 exc_rv", {30'd0, exception, result_valid}, 32'd0);
    reset = 1'b0; md_ready = 1'b1; md_result = 32'd4;
    step();
    md_ready = 1'b0; #1;
    chk("rst2 late_ready", {30'd0, busy, result_valid}, 32'd0);
    chk("rst2 late_result", result, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Sequencer that lets the execute stage share the iterative multiply/divide unit with the single-cycle ALU. On a mult or div instruction it captures operands, issues a one-cycle start pulse to the multdiv unit, and stalls the pipeline latches until the unit reports ready or a timeout expires. It then presents the result and exception for one cycle and keeps the result held afterwards. It sits between the execute-stage decode (ALU opcode) and the multdiv instance, and drives the pipeline latch-disable.

## Interface
- WIDTH, 32, datapath width
- TIMEOUT, 40, maximum WAIT cycles before forced exception
- CNT_W, 6, counter width; must satisfy 2^CNT_W > TIMEOUT
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  execute stage holds a valid R-type instruction
- aluop  in  5  ALU opcode field ir[6:2]
- operand_a  in  WIDTH  rs value
- operand_b  in  WIDTH  rt value
- cancel  in  1  abort the in-flight operation
- md_ctrl_mult  out  1  one-cycle multiply start pulse
- md_ctrl_div  out  1  one-cycle divide start pulse
- md_operand_a  out  WIDTH  captured operand A, stable through operation
- md_operand_b  out  WIDTH  captured operand B
- md_result  in  WIDTH  multdiv data_result
- md_exception  in  1  multdiv data_exception
- md_ready  in  1  multdiv data_resultRDY
- stall  out  1  disable pipeline latches (combinational)
- busy  out  1  state != IDLE
- result  out  WIDTH  captured result, held until next capture
- exception  out  1  captured exception, held with result
- result_valid  out  1  result/exception valid this cycle

## Operation
- is_md = op_valid & (aluop == 5'b00110 (MULT) | aluop == 5'b00111 (DIV)).
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if is_md, then stall=1 this cycle and capture operand_a/b plus the op kind at the edge, then go to ISSUE. Otherwise stall=0.
- ISSUE: assert md_ctrl_mult or md_ctrl_div per captured kind for exactly this cycle. stall=1. Clear counter. Go to WAIT. md_ready is ignored in ISSUE.
- WAIT: stall=1; counter increments each cycle.
  - If md_ready: capture md_result and md_exception, go to DONE.
  - Else if counter == TIMEOUT-1: capture result=0, exception=1, go to DONE.
- DONE: stall=0, result_valid=1; the pipeline advances at this edge. Go unconditionally to IDLE. op_valid is not evaluated in DONE, so the completing instruction cannot retrigger.
- cancel in ISSUE/WAIT/DONE: next state IDLE; stall=0 and result_valid=0 in that cycle; result/exception unchanged. cancel in IDLE has no effect, and an is_md in the same cycle is not accepted.
- Priority: reset > cancel > md_ready > timeout.
- md_operand_a/b hold their captured values from the accept edge until the next accept.

## Timing
- Reset: state IDLE, counter 0; every output 0 (md_ctrl_*, md_operand_*, stall, busy, result, exception, result_valid).
- With md_ready first seen in WAIT cycle k (k=0 first WAIT cycle), stall is high for k+3 cycles (accept, ISSUE, WAIT 0..k). result_valid is high in the following cycle.
- Timeout: stall is high for TIMEOUT+2 cycles; result_valid with exception=1 follows.
- Back-to-back mult/div: the next instruction may be accepted in the cycle right after DONE.
- md_ctrl_*, result, exception, result_valid and busy are registered. Only stall is combinational (from state and is_md).

## Structure
- Shared package/header multdiv_defs: ALU_MULT=5'b00110, ALU_DIV=5'b00111, state encodings (2-bit).
- Single module; no sub-module required. The timeout counter stays inline.

## Test plan
- MULT a=7, b=6; model md_ready in WAIT cycle 3 with md_result=42 -> md_ctrl_mult is a single pulse, stall high 6 cycles, result_valid=1 with result=42, exception=0; result holds 42 afterwards.
- DIV a=10, b=0; md_ready with md_exception=1, md_result=0 -> exception=1 with result_valid; md_ctrl_div pulsed, md_ctrl_mult never asserted.
- md_ready never asserted, TIMEOUT=40 -> stall high 42 cycles, then result=0, exception=1, result_valid=1.
- cancel in WAIT cycle 2 -> stall drops that cycle, no result_valid, state IDLE next cycle, previous result unchanged.
- Two consecutive MULTs (3×4, 5×5), each ready at k=0 -> two separate issue pulses, results 12 then 25; the second is accepted the cycle after the first DONE.
- Reset asserted mid-WAIT -> all outputs 0 the next cycle; a late md_ready after reset is ignored.
